// File: rtl/bus_fabric.sv
// Address-decoding bus fabric: one CPU master, NSLOTS I/O slots plus a
// default memory target, with per-target wait states and an access timeout.
module bus_fabric #(
  parameter int                  NSLOTS    = 8,
  parameter logic [15:0]         IO_BASE   = 16'hE600,
  parameter int                  SLOT_BITS = 5,
  parameter logic [NSLOTS*4-1:0] SLOT_WS   = '0,
  parameter int                  MEM_WS    = 0,
  parameter int                  TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_valid,
  input  logic                cpu_read,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_dout,
  output logic [7:0]          cpu_din,
  output logic                cpu_ready,
  output logic [NSLOTS-1:0]   dev_sel,
  output logic                dev_we,
  output logic [15:0]         dev_addr,
  output logic [7:0]          dev_wdata,
  input  logic [NSLOTS*8-1:0] dev_rdata,
  input  logic [NSLOTS-1:0]   dev_ready,
  output logic                mem_sel,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ready,
  input  logic                err_clr,
  output logic                bus_err,
  output logic [15:0]         err_addr
);

  localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] IO_LO = {1'b0, IO_BASE};
  localparam logic [16:0] IO_HI =
    IO_LO + 17'(NSLOTS << SLOT_BITS);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e          state_q, state_d;
  logic            mem_q, mem_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            rd_q, rd_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      din_q, din_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [15:0]     eaddr_q, eaddr_d;

  logic [16:0]     off;
  logic            in_io;
  logic [SW-1:0]   slot_dec;
  logic [3:0]      ws_dec;
  logic            tgt_rdy;
  logic [7:0]      tgt_data;
  logic [TW-1:0]   tcnt_inc;
  logic            start, done, tmo;

  assign off      = {1'b0, cpu_addr} - IO_LO;
  assign in_io    = ({1'b0, cpu_addr} >= IO_LO) &&
                    ({1'b0, cpu_addr} <  IO_HI);
  assign slot_dec = SW'(off >> SLOT_BITS);
  assign ws_dec   = in_io ? 4'(SLOT_WS >> {slot_dec, 2'b00})
                          : 4'(MEM_WS);

  assign tgt_rdy  = mem_q ? mem_ready : dev_ready[slot_q];
  assign tgt_data = mem_q ? mem_rdata
                          : dev_rdata[{slot_q, 3'b000} +: 8];

  // The cpu_ready cycle blocks a new start so accesses never overlap.
  assign start    = (state_q == IDLE) && cpu_valid && !rdy_q;
  assign tcnt_inc = tcnt_q + 1'b1;
  assign done     = (state_q == ACCESS) && (wcnt_q == 4'd0) &&
                    tgt_rdy;
  assign tmo      = (state_q == ACCESS) && !done &&
                    (tcnt_inc == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mem_q   <= 1'b0;
      slot_q  <= '0;
      rd_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      wcnt_q  <= 4'd0;
      tcnt_q  <= '0;
      din_q   <= 8'hFF;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      eaddr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      slot_q  <= slot_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    slot_d  = slot_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    din_d   = din_q;
    rdy_d   = 1'b0;
    err_d   = err_q;
    eaddr_d = eaddr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          mem_d   = !in_io;
          slot_d  = in_io ? slot_dec : '0;
          rd_d    = cpu_read;
          addr_d  = cpu_addr;
          wdata_d = cpu_dout;
          wcnt_d  = ws_dec;
          tcnt_d  = '0;
        end
      end
      ACCESS: begin
        tcnt_d = tcnt_inc;
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end
        if (done) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (rd_q) begin
            din_d = tgt_data;
          end
        end else if (tmo) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          din_d   = 8'hFF;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timeout on the same edge as err_clr keeps the flag set.
    if (tmo) begin
      err_d   = 1'b1;
      eaddr_d = addr_q;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    dev_sel = '0;
    mem_sel = 1'b0;
    dev_we  = 1'b0;
    if (state_q == ACCESS) begin
      dev_we = !rd_q;
      if (mem_q) begin
        mem_sel = 1'b1;
      end else begin
        dev_sel = NSLOTS'(1) << slot_q;
      end
    end
  end

  assign cpu_din   = din_q;
  assign cpu_ready = rdy_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign bus_err   = err_q;
  assign err_addr  = eaddr_q;

endmodule
